// File: rtl/icache_fill_ctrl.sv
// Cache block fill controller: issues WORDS pipelined memory reads for a missed block,
// streams returned words into the data array, then writes the tag entry for one cycle.
module icache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_grant,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    output logic              memory_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_data,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic              fsm_busy,
    output logic              fill_done
);
    localparam int IDX_W  = $clog2(WORDS);
    localparam int OFF_W  = IDX_W + 1;
    localparam int BASE_W = ADDR_W - OFF_W;
    localparam int CNT_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  recv_cnt_q;
    logic [BASE_W-1:0] base_q;
    logic [ADDR_W-1:0] miss_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (miss_detected) begin
                        base_q      <= miss_address[ADDR_W-1:OFF_W];
                        miss_addr_q <= miss_address;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end
                end
                FILL: begin
                    // Issue and receive counters advance independently so latency pipelines.
                    if (memory_en) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    if (mem_data_valid) begin
                        recv_cnt_q <= recv_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        memory_en        = 1'b0;
        memory_address   = '0;
        cache_addr       = '0;
        cache_data       = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fsm_busy         = 1'b0;
        fill_done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                fsm_busy         = 1'b1;
                memory_en        = mem_grant && (issue_cnt_q < CNT_W'(WORDS));
                // Word index is truncated to IDX_W bits so it never carries into the base.
                memory_address   = {base_q, issue_cnt_q[IDX_W-1:0], 1'b0};
                cache_addr       = {base_q, recv_cnt_q[IDX_W-1:0], 1'b0};
                cache_data       = mem_data;
                write_data_array = mem_data_valid;
                if (mem_data_valid && (recv_cnt_q == CNT_W'(WORDS - 1))) begin
                    state_d = TAG;
                end
            end
            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                fill_done       = 1'b1;
                cache_addr      = miss_addr_q;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Miss-handling state machine that sits between the instruction cache and the shared, multi-cycle main memory. It is the initiator side of the cache fill interface. On a cache miss it fetches the full 8-word (16-byte) block from memory and streams each returned word into the cache data array. It then writes the tag/valid entry and releases the pipeline stall. One instance serves the I-cache; the D-cache reuses it behind the memory arbiter.

Parameters:
ADDR_W, 16, address width in bits.
DATA_W, 16, data word width in bits.
WORDS, 8, words per cache block; offset field is log2(WORDS)+1 bits including the byte bit.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
miss_detected  input  1  level from the cache (its stall output); a fill is needed.
miss_address  input  16  faulting fetch address.
mem_grant  input  1  arbiter permits memory issue this cycle.
mem_data  input  16  read data returned by memory.
mem_data_valid  input  1  mem_data is valid this cycle; responses return in issue order.
memory_en  output  1  issue a memory read this cycle.
memory_address  output  16  read address for the issued request.
cache_addr  output  16  address presented to the cache for data/tag writes.
cache_data  output  16  word to write into the cache data array (equals mem_data).
write_data_array  output  1  cache data-array write enable.
write_tag_array  output  1  cache metadata write enable (valid=1, tag, LRU update).
fsm_busy  output  1  fill in progress; the arbiter holds other requestors off.
fill_done  output  1  one-cycle pulse when the block is installed.

Behaviour:
- Reset: state IDLE, issue_cnt=0, recv_cnt=0, latched base=0. All outputs 0. Reset mid-fill aborts the fill; there is no partial-tag write and in-flight mem_data_valid pulses are ignored.
- States: IDLE, FILL, TAG.
- IDLE:
  - fsm_busy=0.
  - When miss_detected=1, latch base=miss_address[15:4] and the full miss_address, zero both counters, and go to FILL next cycle.
  - mem_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy=1.
  - Issue side: while issue_cnt<WORDS and mem_grant=1, drive memory_en=1 and memory_address={base, issue_cnt[2:0], 1'b0}, then increment issue_cnt. At most one request per cycle. If mem_grant=0, memory_en=0 and issue_cnt holds. Once issue_cnt==WORDS, memory_en stays 0.
  - Receive side: cache_addr={base, recv_cnt[2:0], 1'b0}; cache_data=mem_data; write_data_array=mem_data_valid, combinational in the same cycle. recv_cnt increments on each valid.
  - Issue and receive proceed concurrently and independently, so memory latency is fully pipelined.
  - mem_data_valid with recv_cnt==WORDS-1 moves the FSM to TAG next cycle.
  - Changes on miss_detected or miss_address during FILL are ignored; the latched values are used.
- TAG:
  - Exactly one cycle.
  - write_tag_array=1, cache_addr=latched miss_address, fill_done=1, fsm_busy=1, memory_en=0, write_data_array=0.
  - Next state is IDLE. Any mem_data_valid seen in TAG is ignored.
- Back-to-back misses: from IDLE, a new fill may start the cycle after TAG if miss_detected is still 1. The cache is expected to have deasserted its stall after the tag write, so this case is a real new miss.
- Fill latency with grant held and memory latency L: 1 (IDLE→FILL) + L + 7 + 1 (TAG) cycles from miss_detected to fill_done.
- Address arithmetic:
  - The counter fields are exactly 3 bits and never carry into base.
  - The byte bit is always 0.
  - A block at 0xFFF0 issues addresses 0xFFF0..0xFFFE with no wrap into 0x0000.

Test Plan:
- Reset then miss at 0x1234, grant=1, memory latency 4, data words 0..7:
  - memory_address is 0x1230,0x1232,…,0x123E on consecutive cycles.
  - write_data_array pulses 8 times with cache_addr 0x1230..0x123E and cache_data 0..7.
  - write_tag_array and fill_done pulse once with cache_addr=0x1234.
  - Total latency is 13 cycles.
- Grant dropped for 3 cycles after the 2nd issue:
  - memory_en is 0 during the gap and issue_cnt holds.
  - The remaining 6 addresses 0x1234..0x123E issue in order afterwards.
  - fill_done is delayed by exactly 3 cycles.
- miss_address changed to 0x5432 mid-FILL:
  - All issued addresses and the tag write still use 0x123x and 0x1234.
- Block at 0xFFF6:
  - memory_address runs 0xFFF0..0xFFFE.
  - The tag write uses cache_addr=0xFFF6.
- rst=1 asserted after 4 words are received:
  - All outputs are 0 next cycle and the FSM is in IDLE.
  - Stray mem_data_valid pulses cause no writes.
  - A subsequent miss at 0x1a34 performs a full 8-word fill.
- mem_data_valid asserted while IDLE, miss_detected=0:
  - No write_data_array, no state change.
